// File: rtl/instr_mem_loadable.sv
// Loadable instruction memory: a registered 1-cycle fetch port, plus a byte-serial
// program-load port that assembles MS-byte-first words and writes them at run time.
// After reset an INIT sweep writes NOP_WORD to every word before fetches are accepted.
module instr_mem_loadable #(
  parameter int unsigned          INSTR_W  = 16,
  parameter int unsigned          ADDR_W   = 8,
  parameter int unsigned          DEPTH    = 1 << ADDR_W,
  parameter logic [INSTR_W-1:0]   NOP_WORD = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               fetch_req,
  input  logic [ADDR_W-1:0]  fetch_addr,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  output logic               mem_ready,
  input  logic               ld_start,
  input  logic [ADDR_W-1:0]  ld_addr,
  input  logic               ld_valid,
  input  logic [7:0]         ld_byte,
  input  logic               ld_last,
  output logic               ld_ready,
  output logic               ld_done,
  output logic [ADDR_W-1:0]  ld_count
);

  localparam int unsigned BYTES = INSTR_W / 8;
  localparam int unsigned BCW   = (BYTES > 1) ? $clog2(BYTES) : 1;

  typedef enum logic [1:0] {
    ST_INIT,
    ST_RUN,
    ST_LOAD
  } state_t;

  state_t               state_q, state_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic                 instr_valid_q, instr_valid_d;
  logic                 mem_ready_q, mem_ready_d;
  logic                 ld_ready_q, ld_ready_d;
  logic                 ld_done_q, ld_done_d;
  logic [ADDR_W-1:0]    ld_count_q, ld_count_d;
  logic [BCW-1:0]       byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic [ADDR_W-1:0]    wptr_q, wptr_d;
  logic [INSTR_W-1:0]   asm_q, asm_d;

  logic                 mem_we;
  logic [ADDR_W-1:0]    mem_waddr;
  logic [INSTR_W-1:0]   mem_wdata;
  logic [INSTR_W-1:0]   word_full;
  logic [INSTR_W-1:0]   word_pad;
  logic                 word_end;

  logic [INSTR_W-1:0]   mem [DEPTH];

  assign instr       = instr_q;
  assign instr_valid = instr_valid_q;
  assign mem_ready   = mem_ready_q;
  assign ld_ready    = ld_ready_q;
  assign ld_done     = ld_done_q;
  assign ld_count    = ld_count_q;

  // Next-state, write-port and output computation for INIT sweep, RUN fetch and LOAD assembly
  always_comb begin
    state_d       = state_q;
    instr_d       = instr_q;
    instr_valid_d = 1'b0;
    mem_ready_d   = mem_ready_q;
    ld_ready_d    = ld_ready_q;
    ld_done_d     = 1'b0;
    ld_count_d    = ld_count_q;
    byte_cnt_d    = byte_cnt_q;
    clr_ptr_d     = clr_ptr_q;
    wptr_d        = wptr_q;
    asm_d         = asm_q;
    mem_we        = 1'b0;
    mem_waddr     = clr_ptr_q;
    mem_wdata     = NOP_WORD;

    // Incoming byte appended below the bytes already collected; a short final word is
    // left-justified so the missing LS bytes read as zero.
    word_full = (asm_q << 8) | INSTR_W'(ld_byte);
    word_pad  = word_full << (8 * (BYTES - 1 - 32'(byte_cnt_q)));
    word_end  = ld_last || (byte_cnt_q == BCW'(BYTES - 1));

    unique case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q;
        mem_wdata = NOP_WORD;
        if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
          clr_ptr_d   = '0;
          state_d     = ST_RUN;
          mem_ready_d = 1'b1;
        end else begin
          clr_ptr_d = clr_ptr_q + 1'b1;
        end
      end

      ST_RUN: begin
        if (ld_start) begin
          state_d     = ST_LOAD;
          mem_ready_d = 1'b0;
          ld_ready_d  = 1'b1;
          wptr_d      = ld_addr;
          ld_count_d  = '0;
          byte_cnt_d  = '0;
          asm_d       = '0;
        end else if (fetch_req) begin
          instr_valid_d = 1'b1;
          instr_d       = (32'(fetch_addr) < DEPTH) ? mem[fetch_addr] : NOP_WORD;
        end
      end

      ST_LOAD: begin
        if (ld_valid && ld_ready_q) begin
          asm_d = word_full;
          if (word_end) begin
            mem_we     = (32'(wptr_q) < DEPTH);
            mem_waddr  = wptr_q;
            mem_wdata  = word_pad;
            wptr_d     = (wptr_q == ADDR_W'(DEPTH - 1)) ? '0 : wptr_q + 1'b1;
            ld_count_d = (&ld_count_q) ? ld_count_q : ld_count_q + 1'b1;
            byte_cnt_d = '0;
            asm_d      = '0;
            if (ld_last) begin
              state_d     = ST_RUN;
              ld_done_d   = 1'b1;
              ld_ready_d  = 1'b0;
              mem_ready_d = 1'b1;
            end
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // State and registered outputs; reset restarts the clear sweep
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_INIT;
      instr_q       <= NOP_WORD;
      instr_valid_q <= 1'b0;
      mem_ready_q   <= 1'b0;
      ld_ready_q    <= 1'b0;
      ld_done_q     <= 1'b0;
      ld_count_q    <= '0;
      byte_cnt_q    <= '0;
      clr_ptr_q     <= '0;
      wptr_q        <= '0;
      asm_q         <= '0;
    end else begin
      state_q       <= state_d;
      instr_q       <= instr_d;
      instr_valid_q <= instr_valid_d;
      mem_ready_q   <= mem_ready_d;
      ld_ready_q    <= ld_ready_d;
      ld_done_q     <= ld_done_d;
      ld_count_q    <= ld_count_d;
      byte_cnt_q    <= byte_cnt_d;
      clr_ptr_q     <= clr_ptr_d;
      wptr_q        <= wptr_d;
      asm_q         <= asm_d;
    end
  end

  // Single write port shared by the clear sweep and program load; contents are not reset
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

endmodule

// File: tb/tb_instr_mem_loadable.sv
// Randomized bench for instr_mem_loadable against an array-based memory model.
module tb_instr_mem_loadable;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned ADDR_W  = 8;
  localparam int unsigned DEPTH   = 256;

  typedef logic [7:0] byte_q_t[$];

  logic               clk = 1'b0;
  logic               rst;
  logic               fetch_req;
  logic [ADDR_W-1:0]  fetch_addr;
  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               mem_ready;
  logic               ld_start;
  logic [ADDR_W-1:0]  ld_addr;
  logic               ld_valid;
  logic [7:0]         ld_byte;
  logic               ld_last;
  logic               ld_ready;
  logic               ld_done;
  logic [ADDR_W-1:0]  ld_count;

  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  logic [INSTR_W-1:0] ref_mem [DEPTH];
  logic [INSTR_W-1:0] exp_instr;

  instr_mem_loadable #(
    .INSTR_W (INSTR_W),
    .ADDR_W  (ADDR_W),
    .DEPTH   (DEPTH),
    .NOP_WORD('0)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .instr      (instr),
    .instr_valid(instr_valid),
    .mem_ready  (mem_ready),
    .ld_start   (ld_start),
    .ld_addr    (ld_addr),
    .ld_valid   (ld_valid),
    .ld_byte    (ld_byte),
    .ld_last    (ld_last),
    .ld_ready   (ld_ready),
    .ld_done    (ld_done),
    .ld_count   (ld_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    fetch_req  = 1'b0;
    fetch_addr = '0;
    ld_start   = 1'b0;
    ld_addr    = '0;
    ld_valid   = 1'b0;
    ld_byte    = '0;
    ld_last    = 1'b0;
  endtask

  // Model: the whole memory reads NOP after the clear sweep
  task automatic model_clear();
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;
    exp_instr = '0;
  endtask

  // Model: pack bytes MS-first into words, zero-pad the tail, wrap the address
  task automatic model_load(input logic [ADDR_W-1:0] a, input byte_q_t b,
                            output logic [ADDR_W-1:0] cnt);
    int unsigned n = b.size();
    int unsigned nb = INSTR_W / 8;
    int unsigned words = (n + nb - 1) / nb;
    for (int unsigned w = 0; w < words; w++) begin
      logic [INSTR_W-1:0] word = '0;
      for (int unsigned j = 0; j < nb; j++) begin
        int unsigned idx = w * nb + j;
        word = (word << 8) | INSTR_W'((idx < n) ? b[idx] : 8'h00);
      end
      ref_mem[(int'(a) + w) % DEPTH] = word;
    end
    cnt = (words > 255) ? 8'hFF : ADDR_W'(words);
  endtask

  // Counts edges after reset release; mem_ready must appear exactly after edge DEPTH
  task automatic wait_init(input string tag);
    for (int unsigned i = 1; i < DEPTH; i++) begin
      fetch_req  = ($urandom_range(1) == 1);
      fetch_addr = ADDR_W'($urandom);
      ld_start   = ($urandom_range(3) == 0);
      ld_addr    = ADDR_W'($urandom);
      step();
      n_cmp++;
      if ({mem_ready, instr_valid, ld_ready} !== 3'b000) begin
        n_fail++;
        $display("FAIL %s_init_cycle%0d: {mem_ready,instr_valid,ld_ready}=%b expected 000", tag, i, {mem_ready, instr_valid, ld_ready});
      end
    end
    step();
    idle_inputs();
    n_cmp++;
    if ({mem_ready, instr_valid, ld_ready, instr} !== {3'b100, 16'h0000}) begin
      n_fail++;
      $display("FAIL %s_init_done: mem_ready=%b instr_valid=%b ld_ready=%b instr=%h expected 1 0 0 0000", tag, mem_ready, instr_valid, ld_ready, instr);
    end
    model_clear();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({instr, instr_valid, mem_ready, ld_ready, ld_done, ld_count} !== {16'h0000, 4'b0000, 8'h00}) begin
      n_fail++;
      $display("FAIL reset_values: instr=%h valid=%b mem_ready=%b ld_ready=%b ld_done=%b ld_count=%h expected all zero",
               instr, instr_valid, mem_ready, ld_ready, ld_done, ld_count);
    end
    step();
    step();
    rst = 1'b0;
    wait_init("reset");
  endtask

  // Fetch every address in shuffled order with random idle cycles in between
  task automatic test_fetch_all(input string tag);
    int unsigned order [DEPTH];
    for (int unsigned i = 0; i < DEPTH; i++) order[i] = i;
    for (int unsigned i = DEPTH - 1; i > 0; i--) begin
      int unsigned j = $urandom_range(i);
      int unsigned t = order[i];
      order[i] = order[j];
      order[j] = t;
    end
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if ($urandom_range(3) == 0) begin
        fetch_req  = 1'b0;
        fetch_addr = ADDR_W'($urandom);
        step();
        n_cmp++;
        if (instr_valid !== 1'b0 || instr !== exp_instr) begin
          n_fail++;
          $display("FAIL %s_idle: valid=%b instr=%h expected 0 %h (held)", tag, instr_valid, instr, exp_instr);
        end
      end
      fetch_req  = 1'b1;
      fetch_addr = ADDR_W'(order[k]);
      step();
      exp_instr = ref_mem[order[k]];
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== exp_instr) begin
        n_fail++;
        $display("FAIL %s_fetch[%0d]: valid=%b instr=%h expected 1 %h", tag, order[k], instr_valid, instr, exp_instr);
      end
    end
    idle_inputs();
    step();
  endtask

  // Drive one load session with optional gaps and fetch noise; checks handshake and ld_count
  task automatic do_load(input string tag, input logic [ADDR_W-1:0] a, input byte_q_t b,
                         input int unsigned max_gap, input bit fetch_with_start);
    logic [ADDR_W-1:0] exp_cnt;
    model_load(a, b, exp_cnt);
    ld_start   = 1'b1;
    ld_addr    = a;
    fetch_req  = fetch_with_start;
    fetch_addr = ADDR_W'($urandom);
    step();
    ld_start = 1'b0;
    n_cmp++;
    if ({ld_ready, mem_ready, instr_valid} !== 3'b100 || instr !== exp_instr) begin
      n_fail++;
      $display("FAIL %s_start: ld_ready=%b mem_ready=%b valid=%b instr=%h expected 1 0 0 %h", tag, ld_ready, mem_ready, instr_valid, instr, exp_instr);
    end
    for (int i = 0; i < b.size(); i++) begin
      int unsigned gaps = (max_gap == 0) ? 0 : $urandom_range(max_gap);
      for (int unsigned g = 0; g < gaps; g++) begin
        ld_valid  = 1'b0;
        ld_byte   = 8'($urandom);
        ld_last   = ($urandom_range(1) == 1);
        fetch_req = ($urandom_range(1) == 1);
        step();
        n_cmp++;
        if ({ld_ready, ld_done, instr_valid} !== 3'b100) begin
          n_fail++;
          $display("FAIL %s_gap: ld_ready=%b ld_done=%b valid=%b expected 1 0 0", tag, ld_ready, ld_done, instr_valid);
        end
      end
      ld_valid  = 1'b1;
      ld_byte   = b[i];
      ld_last   = (i == b.size() - 1);
      fetch_req = ($urandom_range(1) == 1);
      ld_start  = ($urandom_range(3) == 0);
      ld_addr   = ADDR_W'($urandom);
      step();
      if (i != b.size() - 1) begin
        n_cmp++;
        if ({ld_ready, ld_done, instr_valid, mem_ready} !== 4'b1000) begin
          n_fail++;
          $display("FAIL %s_byte%0d: ld_ready=%b ld_done=%b valid=%b mem_ready=%b expected 1 0 0 0", tag, i, ld_ready, ld_done, instr_valid, mem_ready);
        end
      end
    end
    idle_inputs();
    n_cmp++;
    if ({ld_done, ld_ready, mem_ready, instr_valid} !== 4'b1010 || ld_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s_done: ld_done=%b ld_ready=%b mem_ready=%b valid=%b ld_count=%0d expected 1 0 1 0 count %0d",
               tag, ld_done, ld_ready, mem_ready, instr_valid, ld_count, exp_cnt);
    end
    step();
    n_cmp++;
    if (ld_done !== 1'b0 || ld_count !== exp_cnt) begin
      n_fail++;
      $display("FAIL %s_done_pulse: ld_done=%b ld_count=%0d expected 0 %0d", tag, ld_done, ld_count, exp_cnt);
    end
  endtask

  task automatic test_load_basic();
    byte_q_t b = '{8'h41, 8'h05, 8'h42, 8'h0A, 8'h03, 8'h12, 8'h53, 8'h00};
    logic [15:0] want [4] = '{16'h4105, 16'h420A, 16'h0312, 16'h5300};
    do_load("basic", 8'h00, b, 0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      fetch_req  = 1'b1;
      fetch_addr = ADDR_W'(k);
      step();
      exp_instr = want[k];
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== want[k]) begin
        n_fail++;
        $display("FAIL basic_fetch[%0d]: valid=%b instr=%h expected 1 %h", k, instr_valid, instr, want[k]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_wrap();
    byte_q_t b = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    logic [ADDR_W-1:0] addrs [2] = '{8'hFF, 8'h00};
    logic [15:0]       want  [2] = '{16'hAABB, 16'hCCDD};
    do_load("wrap", 8'hFF, b, 0, 1'b0);
    for (int k = 0; k < 2; k++) begin
      fetch_req  = 1'b1;
      fetch_addr = addrs[k];
      step();
      exp_instr = want[k];
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== want[k]) begin
        n_fail++;
        $display("FAIL wrap_fetch[%h]: valid=%b instr=%h expected 1 %h", addrs[k], instr_valid, instr, want[k]);
      end
    end
    idle_inputs();
    step();
  endtask

  task automatic test_gaps_odd();
    byte_q_t b = '{8'h12, 8'h34, 8'h56};
    logic [ADDR_W-1:0] a = ADDR_W'($urandom_range(8'hF0, 8'h10));
    logic [15:0] want [2] = '{16'h1234, 16'h5600};
    do_load("odd", a, b, 3, 1'b0);
    for (int k = 0; k < 2; k++) begin
      fetch_req  = 1'b1;
      fetch_addr = a + ADDR_W'(k);
      step();
      exp_instr = want[k];
      n_cmp++;
      if (instr_valid !== 1'b1 || instr !== want[k]) begin
        n_fail++;
        $display("FAIL odd_fetch[%h]: valid=%b instr=%h expected 1 %h", fetch_addr, instr_valid, instr, want[k]);
      end
    end
    idle_inputs();
    step();
  endtask

  // ld_start together with fetch_req: the fetch is dropped
  task automatic test_fetch_blocked();
    byte_q_t b = '{8'h9C, 8'h3E};
    do_load("blocked", ADDR_W'($urandom), b, 1, 1'b1);
  endtask

  task automatic test_random_loads();
    for (int s = 0; s < 6; s++) begin
      byte_q_t b;
      int unsigned n = $urandom_range(12, 1);
      for (int unsigned i = 0; i < n; i++) b.push_back(8'($urandom));
      do_load($sformatf("rand%0d", s), ADDR_W'($urandom), b, 2, ($urandom_range(1) == 1));
    end
    test_fetch_all("rand");
  endtask

  task automatic test_reset_mid_load();
    ld_start = 1'b1;
    ld_addr  = 8'h20;
    step();
    ld_start = 1'b0;
    ld_valid = 1'b1;
    ld_byte  = 8'h77;
    step();
    ld_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({ld_ready, mem_ready, ld_done, ld_count} !== {3'b000, 8'h00}) begin
      n_fail++;
      $display("FAIL midload_reset: ld_ready=%b mem_ready=%b ld_done=%b ld_count=%0d expected 0 0 0 0", ld_ready, mem_ready, ld_done, ld_count);
    end
    idle_inputs();
    step();
    rst = 1'b0;
    wait_init("midload");
    test_fetch_all("after_reset");
  endtask

  initial begin
    test_reset();
    test_fetch_all("cleared");
    test_load_basic();
    test_wrap();
    test_gaps_odd();
    test_fetch_blocked();
    test_random_loads();
    test_reset_mid_load();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
